// File: rtl/gate_sweep.sv
// gate_sweep: exhaustive truth-table sweep of a small combinational gate.
// Drives every input vector, lets it settle, samples and scores the output.
module gate_sweep #(
    parameter int N_IN   = 1,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 first_fail_valid
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN:0]   ERR_MAX  = NV[N_IN:0];
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NV-1:0]     exp_q, exp_d;
    logic [N_IN-1:0]   din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffok_q, ffok_d;
    logic              mismatch;
    logic [N_IN:0]     err_nxt;

    // Score the vector being sampled; count saturates at the vector total.
    always_comb begin
        mismatch = (dut_out != exp_q[vec_q]);
        err_nxt  = err_q;
        if (mismatch && (err_q != ERR_MAX)) begin
            err_nxt = err_q + ERR_ONE;
        end
    end

    // Next-state and registered-output computation for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffok_d  = ffok_q;
        unique case (state_q)
            S_IDLE: begin
                din_d  = '0;
                busy_d = 1'b0;
                if (start) begin
                    exp_d   = expected;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ffv_d   = '0;
                    ffok_d  = 1'b0;
                    pass_d  = 1'b0;
                    din_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    din_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    din_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    err_d = err_nxt;
                    if (mismatch && !ffok_q) begin
                        ffv_d  = vec_q;
                        ffok_d = 1'b1;
                    end
                    if (&vec_q) begin
                        din_d   = '0;
                        done_d  = 1'b1;
                        pass_d  = (err_nxt == '0);
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + VEC_ONE;
                        din_d   = vec_q + VEC_ONE;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                din_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffok_q  <= ffok_d;
        end
    end

    assign dut_in           = din_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffok_q;

endmodule

// File: tb/tb_gate_sweep.sv
// tb_gate_sweep: cycle-index reference model plus directed and random sweeps.
// Main instance N_IN=2/SETTLE=1; a second N_IN=1/SETTLE=2 instance for inverter cases.
module tb_gate_sweep;

    localparam int NV  = 4;
    localparam int P   = 2;
    localparam int TOT = NV * P + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, abort;
    logic [3:0] expected;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic [1:0] ffv;
    logic       ffvalid;
    logic [3:0] gate_tt;

    assign dut_out = gate_tt[dut_in];

    gate_sweep #(.N_IN(2), .SETTLE(1)) u_main (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .expected(expected), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(ffv), .first_fail_valid(ffvalid)
    );

    logic       s_start, s_abort, s_inv;
    logic [1:0] s_exp;
    logic [0:0] s_din;
    logic       s_dout;
    logic       s_busy, s_done, s_pass;
    logic [1:0] s_err;
    logic [0:0] s_ffv;
    logic       s_ffvalid;

    assign s_dout = s_inv & ~s_din[0];

    gate_sweep #(.N_IN(1), .SETTLE(2)) u_inv (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .expected(s_exp), .dut_in(s_din), .dut_out(s_dout),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .first_fail_vec(s_ffv), .first_fail_valid(s_ffvalid)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    endtask

    // Reference model: cycle k (1..TOT) after accept; k==TOT is the done cycle.
    bit       m_act;
    int       m_k;
    logic [3:0] m_exp;
    int       m_err;
    int       m_ffv;
    bit       m_ffvalid;
    bit       m_pass;

    function automatic bit mis_at(input int k);
        return gate_tt[k / P - 1] != m_exp[k / P - 1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 0; m_k <= 0; m_exp <= '0; m_err <= 0;
            m_ffv <= 0; m_ffvalid <= 0; m_pass <= 0;
        end else if (!m_act) begin
            if (start) begin
                m_act <= 1; m_k <= 1; m_exp <= expected; m_err <= 0;
                m_ffv <= 0; m_ffvalid <= 0; m_pass <= 0;
            end
        end else if (m_k == TOT) begin
            m_act <= 0;
        end else if (abort) begin
            m_act <= 0;
        end else begin
            if (m_k % P == 0) begin
                m_err <= m_err + int'(mis_at(m_k));
                if (mis_at(m_k) && !m_ffvalid) begin
                    m_ffvalid <= 1;
                    m_ffv <= m_k / P - 1;
                end
                if (m_k / P == NV) m_pass <= (m_err + int'(mis_at(m_k))) == 0;
            end
            m_k <= m_k + 1;
        end
    end

    logic [1:0]  m_din;
    logic [2:0]  m_err3;
    logic [1:0]  m_ffv2;
    logic [10:0] got_v, exp_v;
    assign m_din  = (m_act && m_k < TOT) ? 2'((m_k - 1) / P) : 2'd0;
    assign m_err3 = m_err[2:0];
    assign m_ffv2 = m_ffv[1:0];
    assign got_v  = {busy, done, pass, err_count, ffv, ffvalid, dut_in};
    assign exp_v  = {m_act, m_act && (m_k == TOT), m_pass, m_err3,
                     m_ffv2, m_ffvalid, m_din};

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        chk("cycle", int'(got_v), int'(exp_v));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) tick();
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic sweep_main(input logic [3:0] e, input logic [3:0] tt,
                              output int dc);
        wait_idle();
        gate_tt = tt; expected = e; start = 1'b1;
        tick();
        start = 1'b0; dc = 0;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            if (done) dc = c;
            else tick();
        end
        tick();
    endtask

    int dc;

    initial begin
        rst = 1'b1; start = 0; abort = 0; expected = '0; gate_tt = '0;
        s_start = 0; s_abort = 0; s_inv = 1; s_exp = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_din", int'(dut_in), 0);
        chk("rst_pass", int'(s_pass), 0);

        // Inverter, expected 01: vectors 0,0,0,1,1,1 then done at cycle 7.
        s_exp = 2'b01; s_inv = 1; s_start = 1;
        tick();
        s_start = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 6) chk("inv_din", int'(s_din), (c - 1) / 3);
            chk("inv_done", int'(s_done), int'(c == 7));
            if (c < 7) tick();
        end
        chk("inv_pass", int'(s_pass), 1);
        chk("inv_err", int'(s_err), 0);
        chk("inv_ffvalid", int'(s_ffvalid), 0);
        tick();

        // Output tied low against expected 01.
        s_inv = 0; s_start = 1;
        tick();
        s_start = 0; dc = 0;
        for (int c = 1; c <= 20 && dc == 0; c++) begin
            if (s_done) dc = c;
            else tick();
        end
        chk("tie0_done_cyc", dc, 7);
        chk("tie0_pass", int'(s_pass), 0);
        chk("tie0_err", int'(s_err), 1);
        chk("tie0_ffv", int'(s_ffv), 0);
        chk("tie0_ffvalid", int'(s_ffvalid), 1);
        tick();

        // Expect AND, gate is OR.
        sweep_main(4'b1000, 4'b1110, dc);
        chk("or_done_cyc", dc, 9);
        chk("or_err", int'(err_count), 2);
        chk("or_ffv", int'(ffv), 1);
        chk("or_pass", int'(pass), 0);
        chk("model_err", m_err, 2);
        chk("model_ffv", m_ffv, 1);

        // Restart and expected changes mid-sweep must not disturb it.
        wait_idle();
        gate_tt = 4'b1110; expected = 4'b1000; start = 1;
        tick();
        start = 0; dc = 0;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            if (done) dc = c;
            else begin
                start = (c == 3);
                if (c == 5) expected = 4'b0110;
                tick();
            end
        end
        start = 0;
        chk("dist_done_cyc", dc, 9);
        chk("dist_err", int'(err_count), 2);
        chk("dist_ffv", int'(ffv), 1);
        tick();

        // Abort on cycle 4: the vector-1 compare is discarded.
        wait_idle();
        gate_tt = 4'b1110; expected = 4'b1000; start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_err", int'(err_count), 0);
        chk("abort_pass", int'(pass), 0);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_done", int'(done), 0);
            tick();
        end
        sweep_main(4'b1110, 4'b1110, dc);
        chk("post_abort_done_cyc", dc, 9);
        chk("post_abort_pass", int'(pass), 1);
        chk("post_abort_err", int'(err_count), 0);

        // Reset between edges in cycle 6.
        wait_idle();
        gate_tt = 4'b1110; expected = 4'b1000; start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        chk("pre_rst_err", int'(err_count), 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_din", int'(dut_in), 0);
        chk("mid_rst_err", int'(err_count), 0);
        chk("mid_rst_ffvalid", int'(ffvalid), 0);
        tick();
        tick();
        rst = 0;
        sweep_main(4'b1000, 4'b1110, dc);
        chk("post_rst_done_cyc", dc, 9);
        chk("post_rst_err", int'(err_count), 2);

        // Random traffic; gate only changes while idle.
        for (int b = 0; b < 40; b++) begin
            start = 0; abort = 0;
            wait_idle();
            gate_tt = 4'($urandom);
            for (int i = 0; i < 30; i++) begin
                start = ($urandom_range(3) == 0);
                abort = ($urandom_range(15) == 0);
                expected = ($urandom_range(1) == 0) ? gate_tt : 4'($urandom);
                tick();
            end
        end
        start = 0; abort = 0;
        wait_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gate_sweep.md
GATE_SWEEP -- requirements
Module: gate_sweep

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have these parameters:
- N_IN, default 1: number of inputs on the gate under test; legal range 1..4.
- SETTLE, default 2: number of cycles each input vector is held before sampling; must be >= 1.

REQ-003 The block SHALL have these ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: request to begin a sweep.
- abort, input, 1: synchronous sweep cancel.
- expected, input, 2**N_IN: expected truth table; bit i is the expected output for input vector i.
- dut_in, output, N_IN: vector driven to the gate under test.
- dut_out, input, 1: output of the gate under test.
- busy, output, 1: sweep in progress.
- done, output, 1: one-cycle pulse at sweep end.
- pass, output, 1: sweep had no mismatches.
- err_count, output, N_IN+1: number of mismatching vectors.
- first_fail_vec, output, N_IN: lowest input vector that mismatched.
- first_fail_valid, output, 1: first_fail_vec holds a valid vector.

Function
REQ-004 The block SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-005 In IDLE with start=1 at a clock edge, the block SHALL:
- capture expected into an internal register;
- set vec=0, cnt=0, err_count=0, first_fail_valid=0, pass=0;
- enter SETTLE.

REQ-006 In SETTLE, dut_in SHALL equal vec; cnt SHALL increment each cycle; the FSM SHALL enter SAMPLE on the edge where cnt==SETTLE-1.
REQ-007 In SAMPLE, dut_in SHALL still equal vec, and at the exit edge the block SHALL compare dut_out with expected_reg[vec].
REQ-008 On a mismatch, err_count SHALL increment. If first_fail_valid==0, first_fail_vec SHALL take vec and first_fail_valid SHALL go to 1.
REQ-009 From SAMPLE:
- if vec == 2**N_IN-1, the FSM SHALL enter DONE;
- otherwise vec SHALL increment, cnt SHALL clear to 0, and the FSM SHALL enter SETTLE.

REQ-010 In DONE, done SHALL be 1 for exactly one cycle and pass SHALL equal (err_count==0); the FSM SHALL then return to IDLE.
REQ-011 Each vector SHALL occupy SETTLE+1 cycles. done SHALL assert exactly 2**N_IN*(SETTLE+1)+1 cycles after the start-accept edge.
REQ-012 busy SHALL be 1 in SETTLE, SAMPLE and DONE, and 0 in IDLE.
REQ-013 start while busy=1 SHALL be ignored; the sweep in progress SHALL be unaffected.
REQ-014 Changes to the expected input during a sweep SHALL be ignored, because only the captured copy is used.
REQ-015 abort=1 in SETTLE or SAMPLE SHALL return the FSM to IDLE at the next edge with no done pulse; the results registers keep their partial values and pass SHALL be 0.
REQ-016 If abort and the final SAMPLE exit occur on the same edge, abort SHALL win: no done pulse, and the final compare is discarded.
REQ-017 abort in IDLE or DONE SHALL have no effect.
REQ-018 pass, err_count, first_fail_vec and first_fail_valid SHALL hold their values in IDLE until the next accepted start.
REQ-019 err_count SHALL saturate at 2**N_IN, which its width guarantees without wrap.
REQ-020 In IDLE, dut_in SHALL be 0.

Reset
REQ-021 While rst=1, regardless of clk, the block SHALL hold:
- state=IDLE;
- dut_in=0, vec=0, cnt=0;
- busy=0, done=0, pass=0;
- err_count=0, first_fail_vec=0, first_fail_valid=0.

REQ-022 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-023 N_IN=1, SETTLE=2, expected=2'b01, DUT is an inverter. Pulse start -> dut_in sequence 0,0,0,1,1,1; done at cycle 7 after accept; pass=1; err_count=0; first_fail_valid=0.
REQ-024 N_IN=1, expected=2'b01, dut_out tied to 0 -> pass=0; err_count=1; first_fail_vec=0; first_fail_valid=1.
REQ-025 N_IN=2, SETTLE=1, expected=4'b1000 (AND), DUT is an OR gate -> done at cycle 9 after accept; err_count=2; first_fail_vec=1; pass=0.
REQ-026 start re-pulsed at cycle 3 of a sweep, and expected changed mid-sweep -> done timing and results are identical to an undisturbed sweep.
REQ-027 abort at cycle 4 of an N_IN=2 sweep -> IDLE next cycle; no done pulse; busy=0; a following start produces a full, correct sweep.
REQ-028 rst asserted between clock edges mid-sweep -> outputs go to the reset values immediately; no done pulse; the next start completes normally.
